// File: rtl/uart_pix_pack.sv
// Packs UART byte pairs into zero-extended RGB565 FIFO words and counts pixels per frame.
// Optional frame header sync (0x55, 0xAA) is built when UART_SYNC_HDR_EN is defined.
module uart_pix_pack #(
    parameter int FRAME_PIX   = 130560,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_flag,
    output logic [23:0] pix_data,
    output logic        pix_vld,
    output logic        frame_done,
    output logic        byte_err,
    output logic [16:0] pix_cnt
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMR_TC   = TW'(TIMEOUT_CYC - 1);
    localparam logic [16:0]   CNT_LAST = 17'(FRAME_PIX - 1);

`ifdef UART_SYNC_HDR_EN
    typedef enum logic [1:0] {HDR0 = 2'd0, HDR1 = 2'd1, HI = 2'd2, LO = 2'd3} state_t;
    localparam state_t START = HDR0;
`else
    typedef enum logic [1:0] {HI = 2'd0, LO = 2'd1} state_t;
    localparam state_t START = HI;
`endif

    state_t        state, state_nxt;
    logic [7:0]    hi_reg, hi_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [23:0]   pix_data_nxt;
    logic [16:0]   pix_cnt_nxt;
    logic          pix_vld_nxt, frame_done_nxt, byte_err_nxt;
    logic          tmr_tc;

    assign tmr_tc = (timer == TMR_TC);

    // Control registers: state, timer and all strobes/counters
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state      <= START;
            timer      <= '0;
            pix_data   <= 24'h0;
            pix_vld    <= 1'b0;
            frame_done <= 1'b0;
            byte_err   <= 1'b0;
            pix_cnt    <= 17'd0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            pix_data   <= pix_data_nxt;
            pix_vld    <= pix_vld_nxt;
            frame_done <= frame_done_nxt;
            byte_err   <= byte_err_nxt;
            pix_cnt    <= pix_cnt_nxt;
        end
    end

    // High-byte holding register; only meaningful while in LO
    always_ff @(posedge sclk) begin
        hi_reg <= hi_nxt;
    end

    always_comb begin
        state_nxt      = state;
        hi_nxt         = hi_reg;
        timer_nxt      = '0;
        pix_data_nxt   = pix_data;
        pix_vld_nxt    = 1'b0;
        frame_done_nxt = 1'b0;
        byte_err_nxt   = 1'b0;
        pix_cnt_nxt    = pix_cnt;

        case (state)
`ifdef UART_SYNC_HDR_EN
            HDR0: begin
                if (rx_flag && rx_data == 8'h55) begin
                    state_nxt = HDR1;
                end
            end
            HDR1: begin
                if (rx_flag) begin
                    if (rx_data == 8'hAA) begin
                        state_nxt = HI;
                    end else if (rx_data != 8'h55) begin
                        state_nxt = HDR0;
                    end
                end else if (tmr_tc) begin
                    byte_err_nxt = 1'b1;
                    state_nxt    = HDR0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
`endif
            HI: begin
                if (rx_flag) begin
                    hi_nxt    = rx_data;
                    state_nxt = LO;
                end
            end
            LO: begin
                // An accepted byte takes priority over a simultaneous timeout
                if (rx_flag) begin
                    pix_data_nxt = {8'h00, hi_reg, rx_data};
                    pix_vld_nxt  = 1'b1;
                    state_nxt    = HI;
                    if (pix_cnt == CNT_LAST) begin
                        frame_done_nxt = 1'b1;
                        pix_cnt_nxt    = 17'd0;
                        state_nxt      = START;
                    end else begin
                        pix_cnt_nxt = pix_cnt + 17'd1;
                    end
                end else if (tmr_tc) begin
                    byte_err_nxt = 1'b1;
                    hi_nxt       = 8'h00;
                    state_nxt    = HI;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = START;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_pix_pack.sv
// Directed scoreboard bench for uart_pix_pack (FRAME_PIX = 4, TIMEOUT_CYC = 16).
module tb_uart_pix_pack;

    localparam int FRAME_PIX   = 4;
    localparam int TIMEOUT_CYC = 16;

    logic        sclk = 1'b0;
    logic        s_rst;
    logic [7:0]  rx_data;
    logic        rx_flag;
    logic [23:0] pix_data;
    logic        pix_vld;
    logic        frame_done;
    logic        byte_err;
    logic [16:0] pix_cnt;

    typedef struct packed {
        logic [23:0] data;
        logic [16:0] cnt;
        logic        fd;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_vld    = 0;
    int   n_fd     = 0;
    int   n_err    = 0;

    uart_pix_pack #(
        .FRAME_PIX  (FRAME_PIX),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .sclk      (sclk),
        .s_rst     (s_rst),
        .rx_data   (rx_data),
        .rx_flag   (rx_flag),
        .pix_data  (pix_data),
        .pix_vld   (pix_vld),
        .frame_done(frame_done),
        .byte_err  (byte_err),
        .pix_cnt   (pix_cnt)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_flag = 1'b1;
        @(posedge sclk);
        #1;
        rx_flag = 1'b0;
    endtask

    task automatic pair(input logic [7:0] hi, input logic [7:0] lo,
                        input logic [16:0] cnt, input logic fd);
        exp_t e;
        e.data = {8'h00, hi, lo};
        e.cnt  = cnt;
        e.fd   = fd;
        sb_q.push_back(e);
        send(hi);
        send(lo);
    endtask

    task automatic hdr();
`ifdef UART_SYNC_HDR_EN
        send(8'h55);
        send(8'hAA);
`endif
    endtask

    task automatic settle();
        @(negedge sclk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge sclk);
            if (byte_err) n_err++;
            if (frame_done) begin
                n_fd++;
                check("fd_with_vld", {31'd0, pix_vld}, 32'd1);
            end
            if (pix_vld) begin
                n_vld++;
                if (sb_q.size() == 0) begin
                    check("vld_expected", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("pix_data", {8'h0, pix_data}, {8'h0, e.data});
                    check("pix_cnt", {15'h0, pix_cnt}, {15'h0, e.cnt});
                    check("frame_done", {31'h0, frame_done}, {31'h0, e.fd});
                end
            end
        end
    endtask

    initial begin
        exp_t e;
        s_rst   = 1'b1;
        rx_flag = 1'b0;
        rx_data = 8'h00;
        fork
            monitor();
        join_none

        repeat (3) @(posedge sclk);
        #1;
        check("rst_pix_data", {8'h0, pix_data}, 32'h0);
        check("rst_pix_vld", {31'h0, pix_vld}, 32'h0);
        check("rst_frame_done", {31'h0, frame_done}, 32'h0);
        check("rst_byte_err", {31'h0, byte_err}, 32'h0);
        check("rst_pix_cnt", {15'h0, pix_cnt}, 32'h0);
        s_rst = 1'b0;

        // Pair packing and frame wrap
        hdr();
        pair(8'hF8, 8'h1F, 17'd1, 1'b0);
        check("cnt_after_first", {15'h0, pix_cnt}, 32'd1);
        pair(8'h01, 8'h02, 17'd2, 1'b0);
        pair(8'h03, 8'h04, 17'd3, 1'b0);
        pair(8'h05, 8'h06, 17'd0, 1'b1);
        settle();
        check("frame_vld_count", n_vld, 32'd4);
        check("frame_fd_count", n_fd, 32'd1);

        // Timeout discards a lone high byte mid-frame
        hdr();
        pair(8'h11, 8'h11, 17'd1, 1'b0);
        send(8'h12);
        repeat (20) @(posedge sclk);
        #1;
        check("timeout_err_count", n_err, 32'd1);
        check("timeout_cnt_kept", {15'h0, pix_cnt}, 32'd1);
        check("pix_data_hold", {8'h0, pix_data}, 32'h001111);
        pair(8'hAB, 8'hCD, 17'd2, 1'b0);

        // Low byte lands in the terminal-count cycle
        e.data = 24'h002143;
        e.cnt  = 17'd3;
        e.fd   = 1'b0;
        sb_q.push_back(e);
        send(8'h21);
        repeat (TIMEOUT_CYC - 1) @(posedge sclk);
        #1;
        send(8'h43);
        settle();
        check("race_no_err", n_err, 32'd1);
        pair(8'h99, 8'h88, 17'd0, 1'b1);

        // Header sync (plain pixel when headers are not built)
`ifdef UART_SYNC_HDR_EN
        send(8'h00);
        send(8'h55);
        send(8'h55);
        send(8'hAA);
`endif
        pair(8'h01, 8'h02, 17'd1, 1'b0);
        settle();
        check("hdr_vld_count", n_vld, 32'd9);
        check("hdr_err_count", n_err, 32'd1);

        // Reset in the middle of a pixel
        send(8'h77);
        s_rst = 1'b1;
        @(posedge sclk);
        #1;
        check("mid_rst_pix_data", {8'h0, pix_data}, 32'h0);
        check("mid_rst_pix_vld", {31'h0, pix_vld}, 32'h0);
        check("mid_rst_frame_done", {31'h0, frame_done}, 32'h0);
        check("mid_rst_byte_err", {31'h0, byte_err}, 32'h0);
        check("mid_rst_pix_cnt", {15'h0, pix_cnt}, 32'h0);
        s_rst = 1'b0;
        hdr();
        pair(8'h34, 8'h56, 17'd1, 1'b0);
        repeat (3) settle();

        check("final_vld_count", n_vld, 32'd10);
        check("final_fd_count", n_fd, 32'd2);
        check("final_err_count", n_err, 32'd1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
